// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the multi-channel clock divider.
//   ch_state_e  - per-channel state (off, running, running with a pending divisor)
//   DefCntW     - default divisor/counter width
//   DefRstDiv   - default divisor loaded at reset
//   clamp_div() - maps divisors 0 and 1 onto the minimum legal divisor of 2
package clk_div_pkg;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } ch_state_e;

  localparam int unsigned DefCntW   = 16;
  localparam int unsigned DefRstDiv = 2;
  localparam int unsigned MinDiv    = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(MinDiv)) ? 32'(MinDiv) : div;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with a shadow divisor register.
// Ports:
//   i_clk    - clock (rising edge)
//   i_reset  - synchronous active-high reset
//   i_en     - run enable
//   i_sync   - restart the period at cnt=0 (tie low when phase alignment is unused)
//   i_load   - accepted divisor load for this channel (already handshaked)
//   i_div    - requested divisor, clamped to >= 2 here
//   o_clk    - registered divided clock
//   o_tick   - registered pulse in the last cycle of each period
//   o_pend   - a loaded divisor is waiting for the current period to end
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned RST_DIV = DefRstDiv
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);

  ch_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_shadow, w_shadow_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_tick, w_tick_nxt;

  logic [CNT_W-1:0] w_div_req;
  logic [CNT_W-1:0] w_div_flush;
  logic             w_wrap;
  logic [CNT_W:0]   w_half;
  logic             w_run_nxt;

  assign w_div_req   = CNT_W'(clamp_div(32'(i_div)));
  // Divisor in force once any pending value has been folded in.
  assign w_div_flush = (r_state == StPend) ? r_shadow : r_div;
  assign w_wrap      = (r_cnt == r_div - 1'b1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_shadow_nxt = r_shadow;
    unique case (r_state)
      StOff: begin
        w_cnt_nxt = '0;
        if (i_load) w_div_nxt = w_div_req;
        if (i_en) w_state_nxt = StRun;
      end
      StRun, StPend: begin
        if (!i_en || i_sync) begin
          // Disable and sync both restart cleanly and apply any pending divisor now.
          w_state_nxt  = i_en ? StRun : StOff;
          w_cnt_nxt    = '0;
          w_div_nxt    = i_load ? w_div_req : w_div_flush;
          w_shadow_nxt = '0;
        end else begin
          if (w_wrap) begin
            w_cnt_nxt = '0;
            if (r_state == StPend) begin
              w_div_nxt    = r_shadow;
              w_shadow_nxt = '0;
              w_state_nxt  = StRun;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          // A load landing on a wrap still lets the fresh period use the old divisor.
          if (i_load) begin
            w_shadow_nxt = w_div_req;
            w_state_nxt  = StPend;
          end
        end
      end
      default: w_state_nxt = StOff;
    endcase

    w_run_nxt  = (w_state_nxt != StOff);
    w_half     = ({1'b0, w_div_nxt} + 1'b1) >> 1;
    w_clk_nxt  = w_run_nxt && ({1'b0, w_cnt_nxt} < w_half);
    w_tick_nxt = w_run_nxt && !i_sync && (w_cnt_nxt == w_div_nxt - 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StOff;
      r_cnt    <= '0;
      r_div    <= CNT_W'(RST_DIV);
      r_shadow <= '0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_shadow <= w_shadow_nxt;
      r_clk    <= w_clk_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = (r_state == StPend);

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers sharing one config port.
// Optional feature macro: CLK_DIV_MULTI_SYNC_EN adds the 'sync' input for phase alignment.
// Ports:
//   clk_in1   - sole clock
//   reset     - synchronous active-high reset
//   ch_en     - per-channel run enable
//   sync      - (CLK_DIV_MULTI_SYNC_EN only) restart every running channel at cnt=0
//   cfg_valid - divisor load request
//   cfg_ready - addressed channel can take a load (low only while it has one pending)
//   cfg_ch    - target channel; out-of-range indices are accepted and dropped
//   cfg_div   - requested divisor (0 and 1 behave as 2)
//   clk_out   - registered divided clocks
//   tick      - registered end-of-period pulses
//   pend      - per-channel pending-divisor flags
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned CNT_W   = DefCntW,
  parameter  int unsigned RST_DIV = DefRstDiv,
  localparam int unsigned ChW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ChW-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic w_sync;
`ifdef CLK_DIV_MULTI_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // Indices with no channel behind them leave ready high so the request drains.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == ChW'(i)) cfg_ready = !pend[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_load;
    assign w_load = cfg_valid && cfg_ready && (cfg_ch == ChW'(g));

    clk_div_ch #(
      .CNT_W  (CNT_W),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .i_clk  (clk_in1),
      .i_reset(reset),
      .i_en   (ch_en[g]),
      .i_sync (w_sync),
      .i_load (w_load),
      .i_div  (cfg_div),
      .o_clk  (clk_out[g]),
      .o_tick (tick[g]),
      .o_pend (pend[g])
    );
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 16: divisor and counter width in bits, 2..32.
REQ-003 Parameter RST_DIV, default 2: divisor loaded into every channel at reset, 2..2^CNT_W-1.
REQ-004 clk_in1  input  1  sole clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ch_en  input  NUM_CH  per-channel run enable.
REQ-007 cfg_valid  input  1  request to load a new divisor.
REQ-008 cfg_ready  output  1  high when the addressed channel accepts a load; combinational from cfg_ch and channel state.
REQ-009 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-010 cfg_div  input  CNT_W  requested divisor N.
REQ-011 clk_out  output  NUM_CH  registered divided clock per channel.
REQ-012 tick  output  NUM_CH  registered one-cycle pulse in the last cycle of each period.
REQ-013 pend  output  NUM_CH  high while a channel holds an accepted, unapplied divisor.

Function
REQ-014 Each channel SHALL implement the states OFF, RUN and PEND.
REQ-015 OFF->RUN on ch_en=1: cnt SHALL be 0 and the period SHALL start on the next cycle.
REQ-016 RUN or PEND->OFF on ch_en=0 in the next cycle: cnt=0, clk_out=0, tick=0; any pending divisor SHALL be applied immediately.
REQ-017 In RUN, cnt SHALL count 0..N-1 and wrap to 0.
REQ-018 clk_out SHALL be 1 when cnt < (N+1)>>1 and 0 otherwise, giving a period of N cycles; for odd N the high phase is one cycle longer.
REQ-019 tick SHALL be 1 exactly when cnt==N-1.
REQ-020 A divisor below 2 (0 or 1) SHALL be accepted and treated as 2.
REQ-021 A load SHALL occur when cfg_valid&&cfg_ready, stored in the channel's shadow register; RUN->PEND.
REQ-022 cfg_ready SHALL be 0 when the addressed channel is in PEND, 1 otherwise.
REQ-023 A cfg_ch >= NUM_CH SHALL give cfg_ready=1; the load SHALL be dropped with no state change.
REQ-024 In PEND, the new N SHALL take effect at the wrap following cnt==N_old-1; PEND->RUN at the same edge; the old period always completes unbroken.
REQ-025 A load to a channel in OFF SHALL update N directly and leave the channel in OFF, with pend=0.
REQ-026 If a load and a wrap coincide in RUN, the wrap SHALL use N_old; the new N SHALL apply at the next wrap.

Reset
REQ-027 Reset SHALL force every channel to OFF, N=RST_DIV, cnt=0, clk_out=0, tick=0, pend=0, with the shadow register cleared.
REQ-028 Reset SHALL take priority over ch_en, cfg_valid and sync; reset mid-period SHALL abandon the period with no trailing tick.

Configuration
REQ-029 Macro CLK_DIV_MULTI_SYNC_EN defined SHALL add input sync (1 bit); sync=1 SHALL set cnt=0 in every RUN/PEND channel on the next edge, for phase alignment.
REQ-030 sync SHALL apply any pending divisor and SHALL suppress tick that cycle.
REQ-031 With the macro undefined, the sync port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-032 Package clk_div_pkg SHALL hold the channel state enum (OFF, RUN, PEND), default CNT_W and RST_DIV constants, and the clamp-to-2 function.
REQ-033 Per-channel logic SHALL be sub-module clk_div_ch, instantiated NUM_CH times by generate; clk_div_multi holds only cfg decode and ready muxing.

Verification
REQ-034 Reset, then ch_en[0]=1 with N=2 -> clk_out[0] toggles 1,0,1,0; tick[0] on every second cycle.
REQ-035 N=5, running -> clk_out high 3 cycles, low 2 cycles; tick in the 5th cycle of each period.
REQ-036 Mid-period load N=3 onto N=8 -> pend=1; cfg_ready=0 for that channel; the 8-cycle period completes, then 3-cycle periods; pend falls at the wrap.
REQ-037 Second cfg_valid to the same channel while pend=1 -> not accepted; a simultaneous load to another channel -> accepted.
REQ-038 cfg_div=0 and cfg_div=1 -> period 2; cfg_ch=NUM_CH -> no channel changes.
REQ-039 With CLK_DIV_MULTI_SYNC_EN, channels at N=4 and N=6 offset, pulse sync -> both cnt=0 next cycle; ticks coincide every 12 cycles; reset asserted mid-period -> all outputs 0 the next cycle.
